// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder that time-shares one full-adder cell over WIDTH cycles, LSB first.
// The cell is built from two half adders and an OR that merges their carries.
module serial_add_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] opa, opb;
    // acc[0] would only ever be shifted out unread, so the register starts at bit 1
    logic [WIDTH-1:1] acc;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             p, g, s, t, c;
    serial_add_ha h0 (.a(opa[0]), .b(opb[0]), .s(p), .c(g));
    serial_add_ha h1 (.a(p),      .b(cy),     .s(s), .c(t));
    assign c = g | t;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            SUM   <= '0;
            COUT  <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        opa   <= A;
                        opb   <= B;
                        cy    <= CIN;
                        cnt   <= '0;
                        acc   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= {s, acc[WIDTH-1:2]};
                    opa <= {1'b0, opa[WIDTH-1:1]};
                    opb <= {1'b0, opb[WIDTH-1:1]};
                    cy  <= c;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        SUM   <= {s, acc[WIDTH-1:1]};
                        COUT  <= c;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
